// File: rtl/d_cache_wbuf_if.sv
// sram-like request bus: one request/response channel for the cache side or the memory side.
// Latency: none; this is a bundle of wires.
// Backpressure: req is held until addr_ok; data_ok marks completion.
interface d_cache_wbuf_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    // Requester side drives the command, responder side drives the handshakes and read data.
    modport master (output req, wr, size, addr, wdata, input  rdata, addr_ok, data_ok);
    modport slave  (input  req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);
endinterface

// File: rtl/d_cache_wbuf.sv
// Write buffer between the data cache and the sram-like AXI bridge; stores queue, reads wait for an empty queue.
// Latency: write acked 1 cycle after accept; reads take the downstream latency plus one IDLE->R_REQ cycle.
// Backpressure: writes refused while full (registered count) or during the ack cycle; reads held until drained.
module d_cache_wbuf #(
    parameter int PTR_WIDTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    d_cache_wbuf_if.slave  cache_data,
    d_cache_wbuf_if.master mem_data,
    output logic           wbuf_empty
);
    localparam int DEPTH = 1 << PTR_WIDTH;

    typedef struct packed {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } entry_t;

    typedef enum logic [2:0] {IDLE, W_REQ, W_WAIT, R_REQ, R_WAIT} state_t;

    entry_t               queue_q [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0]   count_q, count_d;
    logic                 wr_ack_q;
    state_t               state_q;

    logic                 mem_req_q;
    logic                 mem_wr_q;
    logic [1:0]           mem_size_q;
    logic [31:0]          mem_addr_q;
    logic [31:0]          mem_wdata_q;

    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 rd_accept;
    entry_t               head;

    // count only reaches DEPTH when its top bit is set, so that bit is the full flag
    assign full      = count_q[PTR_WIDTH];
    assign push      = cache_data.req & cache_data.wr & ~full & ~wr_ack_q;
    assign pop       = (state_q == W_WAIT) & mem_data.data_ok;
    assign rd_accept = (state_q == R_REQ) & mem_data.addr_ok;
    assign head      = queue_q[rd_ptr_q];

    assign cache_data.addr_ok = push | rd_accept;
    assign cache_data.data_ok = wr_ack_q | ((state_q == R_WAIT) & mem_data.data_ok);
    assign cache_data.rdata   = (state_q == R_WAIT) ? mem_data.rdata : 32'h0;

    assign mem_data.req   = mem_req_q;
    assign mem_data.wr    = mem_wr_q;
    assign mem_data.size  = mem_size_q;
    assign mem_data.addr  = mem_addr_q;
    assign mem_data.wdata = mem_wdata_q;

    assign wbuf_empty = (count_q == '0) & (state_q == IDLE) & ~wr_ack_q;

    // Pointer and occupancy next state; a simultaneous push and pop leaves the count unchanged
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
        if (push && !pop)      count_d = count_q + (PTR_WIDTH + 1)'(1);
        else if (pop && !push) count_d = count_q - (PTR_WIDTH + 1)'(1);
    end

    // Queue storage; contents need no reset because count gates every read of it
    always_ff @(posedge clk) begin
        if (push) queue_q[wr_ptr_q] <= '{size: cache_data.size, addr: cache_data.addr, wdata: cache_data.wdata};
    end

    // Queue bookkeeping and the one-cycle write acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wr_ack_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wr_ack_q <= push;
        end
    end

    // Drain FSM: one downstream transaction at a time, queued writes always before any read
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_size_q  <= 2'b00;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        state_q     <= W_REQ;
                        mem_req_q   <= 1'b1;
                        mem_wr_q    <= 1'b1;
                        mem_size_q  <= head.size;
                        mem_addr_q  <= head.addr;
                        mem_wdata_q <= head.wdata;
                    end else if (cache_data.req && !cache_data.wr && !wr_ack_q) begin
                        state_q     <= R_REQ;
                        mem_req_q   <= 1'b1;
                        mem_wr_q    <= 1'b0;
                        mem_size_q  <= cache_data.size;
                        mem_addr_q  <= cache_data.addr;
                        mem_wdata_q <= 32'h0;
                    end
                end
                W_REQ, R_REQ: begin
                    if (mem_data.addr_ok) begin
                        state_q     <= (state_q == W_REQ) ? W_WAIT : R_WAIT;
                        mem_req_q   <= 1'b0;
                        mem_wr_q    <= 1'b0;
                        mem_size_q  <= 2'b00;
                        mem_addr_q  <= 32'h0;
                        mem_wdata_q <= 32'h0;
                    end
                end
                W_WAIT, R_WAIT: begin
                    if (mem_data.data_ok) state_q <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    mem_req_q   <= 1'b0;
                    mem_wr_q    <= 1'b0;
                    mem_size_q  <= 2'b00;
                    mem_addr_q  <= 32'h0;
                    mem_wdata_q <= 32'h0;
                end
            endcase
        end
    end
endmodule
